// File: rtl/alu16.sv
// 16-bit registered ALU: one-cycle latency from alu_enable to result, status flags and done.
// Compare/test ops update only the flags; undefined opcodes still pulse done.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             alu_enable,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] term1,
  input  logic [WIDTH-1:0] term2,
  output logic [WIDTH-1:0] result,
  output logic             fl_zero,
  output logic             fl_negative,
  output logic             fl_carry,
  output logic             fl_overflow,
  output logic             done
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_MUL = 6'b000010,
                         OP_DIV = 6'b000011, OP_MOD = 6'b000100, OP_AND = 6'b000101,
                         OP_OR  = 6'b000110, OP_XOR = 6'b000111, OP_NOT = 6'b001000,
                         OP_CMP = 6'b001001, OP_MOV = 6'b001010, OP_RSR = 6'b001011,
                         OP_RSL = 6'b001100, OP_LSR = 6'b001101, OP_LSL = 6'b001110,
                         OP_TST = 6'b001111, OP_INC = 6'b010000, OP_DEC = 6'b010001;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic signed [WIDTH-1:0]   a_s, b_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [SH_W-1:0]           sh, lsl_idx, lsr_idx;
  logic [2*WIDTH-1:0]        rot_r, rot_l;
  logic [WIDTH:0]            sum_p0;
  logic [WIDTH-1:0]          val_p0;
  logic                      c_p0, v_p0, upd_res_p0, upd_flg_p0;

  logic [WIDTH-1:0]          result_p1;
  logic                      z_p1, n_p1, c_p1, v_p1, vld_p1;

  // True when the full-width signed product cannot be represented in WIDTH bits.
  function automatic logic mul_ovf(input logic signed [2*WIDTH-1:0] p);
    mul_ovf = (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
              (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
  endfunction

  assign a_s     = term1;
  assign b_s     = term2;
  assign prod_s  = a_s * b_s;
  assign sh      = term1[SH_W-1:0];
  assign lsr_idx = sh - 1'b1;
  assign lsl_idx = '0 - sh;
  assign rot_r   = {term2, term2} >> sh;
  assign rot_l   = {term2, term2} << sh;

  always_comb begin
    val_p0     = result_p1;
    sum_p0     = '0;
    c_p0       = 1'b0;
    v_p0       = 1'b0;
    upd_res_p0 = 1'b1;
    upd_flg_p0 = 1'b1;
    case (opcode)
      OP_ADD: begin
        sum_p0 = {1'b0, term1} + {1'b0, term2};
        val_p0 = sum_p0[WIDTH-1:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = (term1[WIDTH-1] == term2[WIDTH-1]) && (val_p0[WIDTH-1] != term1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        val_p0     = term1 - term2;
        c_p0       = term1 < term2;
        v_p0       = (term1[WIDTH-1] != term2[WIDTH-1]) && (val_p0[WIDTH-1] != term1[WIDTH-1]);
        upd_res_p0 = (opcode == OP_SUB);
      end
      OP_MUL: begin
        val_p0 = prod_s[WIDTH-1:0];
        c_p0   = mul_ovf(prod_s);
        v_p0   = c_p0;
      end
      OP_DIV: begin
        if (term2 == '0) begin
          val_p0 = '0;
          v_p0   = 1'b1;
        end else if (term1 == MIN_NEG && term2 == '1) begin
          val_p0 = MIN_NEG;
          v_p0   = 1'b1;
        end else begin
          val_p0 = a_s / b_s;
        end
      end
      OP_MOD: begin
        if (term2 == '0) begin
          val_p0 = '0;
          v_p0   = 1'b1;
        end else if (term1 == MIN_NEG && term2 == '1) begin
          val_p0 = '0;
        end else begin
          val_p0 = a_s % b_s;
        end
      end
      OP_AND: val_p0 = term1 & term2;
      OP_OR:  val_p0 = term1 | term2;
      OP_XOR: val_p0 = term1 ^ term2;
      OP_NOT: val_p0 = ~term1;
      OP_MOV: val_p0 = term2;
      OP_RSR: begin
        val_p0 = rot_r[WIDTH-1:0];
        c_p0   = (sh != '0) && val_p0[WIDTH-1];
      end
      OP_RSL: begin
        val_p0 = rot_l[2*WIDTH-1:WIDTH];
        c_p0   = (sh != '0) && val_p0[0];
      end
      OP_LSR: begin
        val_p0 = term2 >> sh;
        c_p0   = (sh != '0) && term2[lsr_idx];
      end
      OP_LSL: begin
        val_p0 = term2 << sh;
        c_p0   = (sh != '0) && term2[lsl_idx];
      end
      OP_TST: begin
        val_p0     = term1 & term2;
        upd_res_p0 = 1'b0;
      end
      OP_INC: begin
        val_p0 = term1 + 1'b1;
        c_p0   = (term1 == '1);
        v_p0   = (term1 == MAX_POS);
      end
      OP_DEC: begin
        val_p0 = term1 - 1'b1;
        c_p0   = (term1 == '0);
        v_p0   = (term1 == MIN_NEG);
      end
      default: begin
        upd_res_p0 = 1'b0;
        upd_flg_p0 = 1'b0;
      end
    endcase
  end

  // Stage p0 -> p1: capture result/flags on enable; done follows enable by one cycle.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      result_p1 <= '0;
      z_p1      <= 1'b0;
      n_p1      <= 1'b0;
      c_p1      <= 1'b0;
      v_p1      <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= alu_enable;
      if (alu_enable && upd_res_p0) result_p1 <= val_p0;
      if (alu_enable && upd_flg_p0) begin
        z_p1 <= (val_p0 == '0);
        n_p1 <= val_p0[WIDTH-1];
        c_p1 <= c_p0;
        v_p1 <= v_p0;
      end
    end
  end

  assign result      = result_p1;
  assign fl_zero     = z_p1;
  assign fl_negative = n_p1;
  assign fl_carry    = c_p1;
  assign fl_overflow = v_p1;
  assign done        = vld_p1;

endmodule

// File: tb/tb_alu16.sv
// Directed-vector bench for alu16; flags are compared as a {Z,N,C,V} nibble.
module tb_alu16;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        alu_enable;
  logic [5:0]  opcode;
  logic [15:0] term1, term2;
  logic [15:0] result;
  logic        fl_zero, fl_negative, fl_carry, fl_overflow, done;

  int total = 0;
  int bad   = 0;

  alu16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_b(rst_b), .alu_enable(alu_enable), .opcode(opcode),
    .term1(term1), .term2(term2), .result(result),
    .fl_zero(fl_zero), .fl_negative(fl_negative), .fl_carry(fl_carry),
    .fl_overflow(fl_overflow), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flg();
    flg = {fl_zero, fl_negative, fl_carry, fl_overflow};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    opcode = op; term1 = a; term2 = b; alu_enable = 1'b1;
    @(posedge clk);
    #1;
    alu_enable = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
    do_op(op, a, b);
    chk({tag, ".res"},  result, er);
    chk({tag, ".flg"},  flg(),  ef);
    chk({tag, ".done"}, done,   1'b1);
  endtask

  initial begin
    rst_b = 1'b1; alu_enable = 1'b0; opcode = '0; term1 = '0; term2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res", result, 16'h0);
    chk("rst.flg", flg(), 4'b0000);
    chk("rst.done", done, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;

    op_chk("add1", 6'h00, 16'd5, 16'd10, 16'h000F, 4'b0000);
    @(posedge clk); #1;
    chk("add1.pulse", done, 1'b0);
    op_chk("add2", 6'h00, 16'hFFF4, 16'h000A, 16'hFFFE, 4'b0100);
    op_chk("add3", 6'h00, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    op_chk("sub1", 6'h01, 16'd16, 16'd10, 16'h0006, 4'b0000);
    op_chk("sub2", 6'h01, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    op_chk("mul1", 6'h02, 16'd5, 16'd10, 16'h0032, 4'b0000);
    op_chk("mul2", 6'h02, 16'hFFFF, 16'd10, 16'hFFF6, 4'b0100);
    op_chk("mul3", 6'h02, 16'h0100, 16'h0100, 16'h0000, 4'b1011);
    op_chk("div1", 6'h03, 16'd30, 16'd3, 16'h000A, 4'b0000);
    op_chk("div2", 6'h03, 16'hFFF9, 16'd2, 16'hFFFD, 4'b0100);
    op_chk("mod1", 6'h04, 16'd30, 16'd3, 16'h0000, 4'b1000);
    op_chk("mod2", 6'h04, 16'd30, 16'd7, 16'h0002, 4'b0000);
    op_chk("mod3", 6'h04, 16'hFFF9, 16'd2, 16'hFFFF, 4'b0100);
    op_chk("div0", 6'h03, 16'd5, 16'd0, 16'h0000, 4'b1001);
    op_chk("mod0", 6'h04, 16'd5, 16'd0, 16'h0000, 4'b1001);
    op_chk("divmin", 6'h03, 16'h8000, 16'hFFFF, 16'h8000, 4'b0101);
    op_chk("modmin", 6'h04, 16'h8000, 16'hFFFF, 16'h0000, 4'b1000);
    op_chk("and", 6'h05, 16'h00F0, 16'h0F00, 16'h0000, 4'b1000);
    op_chk("or",  6'h06, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
    op_chk("xor", 6'h07, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
    op_chk("not", 6'h08, 16'h00F0, 16'h0F00, 16'hFF0F, 4'b0100);
    op_chk("tst", 6'h0F, 16'h00F0, 16'h0F00, 16'hFF0F, 4'b1000);
    op_chk("cmp1", 6'h09, 16'h0030, 16'h0020, 16'hFF0F, 4'b0000);
    op_chk("cmp2", 6'h09, 16'h0020, 16'h0030, 16'hFF0F, 4'b0110);
    op_chk("mov", 6'h0A, 16'h0000, 16'h00AA, 16'h00AA, 4'b0000);
    op_chk("rsr1", 6'h0B, 16'd4, 16'h0F00, 16'h00F0, 4'b0000);
    op_chk("rsl1", 6'h0C, 16'd4, 16'h0F00, 16'hF000, 4'b0100);
    op_chk("lsr1", 6'h0D, 16'd4, 16'h0002, 16'h0000, 4'b1000);
    op_chk("lsl1", 6'h0E, 16'd4, 16'h0002, 16'h0020, 4'b0000);
    op_chk("rsr2", 6'h0B, 16'd1, 16'h0001, 16'h8000, 4'b0110);
    op_chk("lsr2", 6'h0D, 16'd1, 16'h0003, 16'h0001, 4'b0010);
    op_chk("lsl2", 6'h0E, 16'd1, 16'h8001, 16'h0002, 4'b0010);
    op_chk("lsl0", 6'h0E, 16'd0, 16'h8001, 16'h8001, 4'b0100);
    op_chk("inc1", 6'h10, 16'd1, 16'd0, 16'h0002, 4'b0000);
    op_chk("dec1", 6'h11, 16'd1, 16'd0, 16'h0000, 4'b1000);
    op_chk("dec0", 6'h11, 16'd0, 16'd0, 16'hFFFF, 4'b0110);
    op_chk("incmax", 6'h10, 16'hFFFF, 16'd0, 16'h0000, 4'b1010);
    op_chk("decmin", 6'h11, 16'h8000, 16'd0, 16'h7FFF, 4'b0001);

    // Idle cycles: outputs hold and done stays low.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("idle.res", result, 16'h7FFF);
      chk("idle.flg", flg(), 4'b0001);
      chk("idle.done", done, 1'b0);
    end

    op_chk("undef", 6'h3F, 16'h1234, 16'h5678, 16'h7FFF, 4'b0001);

    // Reset asserted after enable is presented but before the sampling edge.
    @(negedge clk);
    opcode = 6'h00; term1 = 16'd1; term2 = 16'd2; alu_enable = 1'b1;
    #2 rst_b = 1'b1;
    #1;
    chk("arst.res", result, 16'h0);
    chk("arst.flg", flg(), 4'b0000);
    chk("arst.done", done, 1'b0);
    @(posedge clk); #1;
    alu_enable = 1'b0;
    chk("arst.res2", result, 16'h0);
    chk("arst.done2", done, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    op_chk("post", 6'h00, 16'd7, 16'd8, 16'h000F, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
